// File: rtl/gray_result_decoder.sv
// gray_result_decoder: bit-serial Gray-to-binary decoder for the adder/subtractor
// result word. Accepts one Gray word and its mode, rebuilds the binary value
// MSB-first at one bit per clock, then presents binary value, carry/borrow,
// sign and magnitude behind a valid/ready handshake.
module gray_result_decoder #(
    parameter int W  = 9,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_gray,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  bin_value,
    output logic          carry_borrow_out,
    output logic          neg,
    output logic [W-1:0]  magnitude,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Two's complement negation modulo 2^W; 2^(W-1) maps onto itself.
    function automatic logic [W-1:0] twos_negate(input logic [W-1:0] v);
        return (~v) + W'(1);
    endfunction

    // One step of the Gray prefix-XOR: binary bit = previous binary bit ^ Gray bit.
    function automatic logic gray_step(input logic prev_bin, input logic gray_bit);
        return prev_bin ^ gray_bit;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [W-1:0]    g_r;
    logic            m_r;
    logic [CW-1:0]   cnt_r;
    logic            prev_r;
    logic [W-1:0]    bin_r;
    logic            cb_r;
    logic            neg_r;
    logic [W-1:0]    mag_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic            accept_s;
    logic            decode_s;
    logic            last_bit_s;
    logic            bit_s;
    logic [W-1:0]    bin_next_s;
    logic            neg_next_s;
    logic [W-1:0]    mag_next_s;

    // Next-state and control decode for the IDLE/DECODE/DONE sequence.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        decode_s     = 1'b0;
        last_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                decode_s = 1'b1;
                if (cnt_r == CW'(0)) begin
                    last_bit_s   = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DECODE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Current decoded bit and the word/flags as they will look once it is written.
    always_comb begin
        bit_s             = gray_step(prev_r, g_r[cnt_r]);
        bin_next_s        = bin_r;
        bin_next_s[cnt_r] = bit_s;
        neg_next_s        = m_r & bin_next_s[W-1];
        if (neg_next_s) begin
            mag_next_s = twos_negate(bin_next_s);
        end else begin
            mag_next_s = bin_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture of the Gray word and mode; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_r <= '0;
            m_r <= 1'b0;
        end else if (accept_s) begin
            g_r <= in_gray;
            m_r <= in_mode;
        end else begin
            g_r <= g_r;
            m_r <= m_r;
        end
    end

    // Serial decode datapath: bit counter, running binary bit and the binary word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            prev_r <= 1'b0;
            bin_r  <= '0;
        end else if (accept_s) begin
            cnt_r  <= CW'(W - 1);
            prev_r <= 1'b0;
            bin_r  <= '0;
        end else if (decode_s) begin
            cnt_r  <= last_bit_s ? cnt_r : (cnt_r - CW'(1));
            prev_r <= bit_s;
            bin_r  <= bin_next_s;
        end else begin
            cnt_r  <= cnt_r;
            prev_r <= prev_r;
            bin_r  <= bin_r;
        end
    end

    // Result flags, loaded once on the edge that writes bit 0 and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_r  <= 1'b0;
            neg_r <= 1'b0;
            mag_r <= '0;
        end else if (last_bit_s) begin
            cb_r  <= bin_next_s[W-1];
            neg_r <= neg_next_s;
            mag_r <= mag_next_s;
        end else begin
            cb_r  <= cb_r;
            neg_r <= neg_r;
            mag_r <= mag_r;
        end
    end

    // Registered handshake/status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s == ST_DECODE);
        end
    end

    assign in_ready         = in_ready_r;
    assign out_valid        = out_valid_r;
    assign busy             = busy_r;
    assign bin_value        = bin_r;
    assign carry_borrow_out = cb_r;
    assign neg              = neg_r;
    assign magnitude        = mag_r;

endmodule

// File: tb/tb_gray_result_decoder.sv
// Self-checking bench for gray_result_decoder: directed cases, backpressure,
// mid-decode reset and random words against an arithmetic reference model.
module tb_gray_result_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_gray;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] bin_value;
    logic       carry_borrow_out;
    logic       neg;
    logic [8:0] magnitude;
    logic       busy;

    int tests;
    int fails;

    gray_result_decoder #(.W(9), .CW(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_gray          (in_gray),
        .in_mode          (in_mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .bin_value        (bin_value),
        .carry_borrow_out (carry_borrow_out),
        .neg              (neg),
        .magnitude        (magnitude),
        .busy             (busy)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: binary = XOR of the Gray word with all of its right shifts.
    function automatic logic [8:0] ref_bin(input logic [8:0] g);
        int acc;
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            acc = acc ^ (int'(g) >> k);
        end
        return acc[8:0];
    endfunction

    // Reference: magnitude as plain arithmetic on the 9-bit value.
    function automatic logic [8:0] ref_mag(input logic [8:0] b, input logic m);
        int v;
        v = int'(b);
        if (m && v >= 256) begin
            v = 512 - v;
        end
        return v[8:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; bp holds out_ready low for 5 cycles in DONE.
    task automatic run_word(input logic [8:0] g, input logic m, input bit bp, input string tag);
        logic [8:0] eb;
        logic [8:0] em;
        logic       en;
        eb = ref_bin(g);
        en = m & eb[8];
        em = ref_mag(eb, m);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 16'(in_ready), 16'd1);
        in_valid  = 1'b1;
        in_gray   = g;
        in_mode   = m;
        out_ready = !bp;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".busy"}, 16'(busy), 16'd1);
        chk({tag, ".in_ready_busy"}, 16'(in_ready), 16'd0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            in_gray  = 9'($urandom);
            in_mode  = 1'($urandom);
            in_valid = 1'($urandom);
        end
        chk({tag, ".early_valid"}, 16'(out_valid), 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        chk({tag, ".bin_value"}, 16'(bin_value), 16'(eb));
        chk({tag, ".carry"}, 16'(carry_borrow_out), 16'(eb[8]));
        chk({tag, ".neg"}, 16'(neg), 16'(en));
        chk({tag, ".magnitude"}, 16'(magnitude), 16'(em));
        if (bp) begin
            for (int j = 0; j < 5; j++) begin
                in_valid = 1'b1;
                in_gray  = 9'($urandom);
                in_mode  = ~in_mode;
                @(negedge clk);
                chk({tag, ".bp_valid"}, 16'(out_valid), 16'd1);
                chk({tag, ".bp_in_ready"}, 16'(in_ready), 16'd0);
                chk({tag, ".bp_bin"}, 16'(bin_value), 16'(eb));
                chk({tag, ".bp_mag"}, 16'(magnitude), 16'(em));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".valid_drop"}, 16'(out_valid), 16'd0);
        chk({tag, ".in_ready_back"}, 16'(in_ready), 16'd1);
        chk({tag, ".bin_hold"}, 16'(bin_value), 16'(eb));
    endtask

    // Directed and random test sequence.
    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = 9'd0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst.out_valid", 16'(out_valid), 16'd0);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.bin_value", 16'(bin_value), 16'd0);
        chk("rst.magnitude", 16'(magnitude), 16'd0);
        chk("rst.neg", 16'(neg), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_gray = 9'h1AB;
        repeat (3) @(negedge clk);
        chk("idle.in_ready", 16'(in_ready), 16'd1);
        chk("idle.no_capture", 16'(busy), 16'd0);

        run_word(9'd62,  1'b0, 1'b0, "g62");
        run_word(9'h101, 1'b0, 1'b0, "g101");
        run_word(9'h102, 1'b1, 1'b0, "g102_sub");
        run_word(9'h102, 1'b0, 1'b0, "g102_add");
        run_word(9'h100, 1'b1, 1'b0, "g100_sub");
        run_word(9'h000, 1'b1, 1'b0, "g0_sub");
        run_word(9'h180, 1'b1, 1'b1, "bp");
        run_word(9'd62,  1'b0, 1'b0, "after_bp");

        // Abort on the 4th DECODE cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_gray  = 9'h101;
        in_mode  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 16'(out_valid), 16'd0);
        chk("abort.busy", 16'(busy), 16'd0);
        chk("abort.bin_value", 16'(bin_value), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.in_ready", 16'(in_ready), 16'd1);
        chk("abort.no_emit", 16'(out_valid), 16'd0);
        run_word(9'd62, 1'b0, 1'b0, "post_abort");

        for (int r = 0; r < 20; r++) begin
            run_word(9'($urandom), 1'($urandom), 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
